// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search block.
// Holds the FSM state encoding, steps-width helper and verdict decode values.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ASK  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Verdict bus is packed as {cmp_lt, cmp_gt, cmp_eq}; exactly one bit is legal.
  localparam logic [2:0] VERDICT_LT = 3'b100;
  localparam logic [2:0] VERDICT_GT = 3'b010;
  localparam logic [2:0] VERDICT_EQ = 3'b001;

  function automatic int steps_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/sar_bounds.sv
// Combinational bound update for the binary search: midpoint, next lo/hi,
// empty-range detection (with guard-bit underflow) and illegal-verdict decode.
module sar_bounds
  import sar_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W:0]   lo_i,
  input  logic [W:0]   hi_i,
  input  logic [W-1:0] guess_i,
  input  logic [2:0]   verdict_i,
  output logic [W:0]   lo_o,
  output logic [W:0]   hi_o,
  output logic [W-1:0] mid_o,
  output logic         lo_gt_hi_o,
  output logic         illegal_o
);

  logic [W:0] guess_ext;
  logic       is_lt;
  logic       is_gt;
  logic       is_eq;

  assign guess_ext = {1'b0, guess_i};
  assign is_lt     = (verdict_i == VERDICT_LT);
  assign is_gt     = (verdict_i == VERDICT_GT);
  assign is_eq     = (verdict_i == VERDICT_EQ);
  assign illegal_o = !(is_lt || is_gt || is_eq);

  // Range bounds never exceed 2^W-1 here, so the W+1-bit sum cannot overflow.
  assign mid_o = W'((lo_i + hi_i) >> 1);

  // hi wraps to all-ones when the guess was 0; the guard bit flags that as empty.
  assign lo_gt_hi_o = (hi_i[W] && !lo_i[W]) || (lo_i > hi_i);

  assign lo_o = is_lt ? (guess_ext + (W+1)'(1)) : lo_i;
  assign hi_o = is_gt ? (guess_ext - (W+1)'(1)) : hi_i;

endmodule

// File: rtl/sar_search.sv
// Binary-search initiator driving an external lt/gt/eq comparator over 0..2^W-1.
// Optional accepted-verdict counter on the steps port when SAR_STEP_CNT_EN is defined.
module sar_search
  import sar_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] guess,
  output logic         guess_valid,
  input  logic         resp_valid,
  input  logic         cmp_lt,
  input  logic         cmp_gt,
  input  logic         cmp_eq,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [W-1:0] result
`ifdef SAR_STEP_CNT_EN
  ,
  output logic [steps_w(W)-1:0] steps
`endif
);

  localparam logic [W:0] HI_INIT = {1'b0, {W{1'b1}}};

  state_t       state_q;
  logic [W:0]   lo_q;
  logic [W:0]   hi_q;
  logic [W-1:0] guess_q;
  logic         gv_q;
  logic         done_q;
  logic         found_q;
  logic         err_q;
  logic [W-1:0] result_q;

  logic [2:0]   verdict;
  logic [W:0]   lo_d;
  logic [W:0]   hi_d;
  logic [W-1:0] mid;
  logic         lo_gt_hi;
  logic         bad_verdict;
  logic         accept;

  assign verdict = {cmp_lt, cmp_gt, cmp_eq};
  assign accept  = (state_q == ASK) && resp_valid;

  sar_bounds #(.W(W)) u_bounds (
    .lo_i       (lo_q),
    .hi_i       (hi_q),
    .guess_i    (guess_q),
    .verdict_i  (verdict),
    .lo_o       (lo_d),
    .hi_o       (hi_d),
    .mid_o      (mid),
    .lo_gt_hi_o (lo_gt_hi),
    .illegal_o  (bad_verdict)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      gv_q     <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            lo_q     <= '0;
            hi_q     <= HI_INIT;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (lo_gt_hi) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            guess_q <= mid;
            gv_q    <= 1'b1;
            state_q <= ASK;
          end
        end
        ASK: begin
          if (resp_valid) begin
            gv_q <= 1'b0;
            if (bad_verdict) begin
              err_q   <= 1'b1;
              found_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else if (verdict == VERDICT_EQ) begin
              found_q  <= 1'b1;
              result_q <= guess_q;
              done_q   <= 1'b1;
              state_q  <= FIN;
            end else begin
              lo_q    <= lo_d;
              hi_q    <= hi_d;
              state_q <= CALC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign guess       = guess_q;
  assign guess_valid = gv_q;
  assign done        = done_q;
  assign found       = found_q;
  assign err         = err_q;
  assign result      = result_q;

`ifdef SAR_STEP_CNT_EN
  localparam int SW = steps_w(W);

  logic [SW-1:0] steps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q <= '0;
    end else if (state_q == IDLE && start) begin
      steps_q <= '0;
    end else if (accept && steps_q != SW'(W + 1)) begin
      steps_q <= steps_q + SW'(1);
    end
  end

  assign steps = steps_q;
`else
  // Without the counter, acceptance is only consumed by the FSM above.
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (W=4): responder modes, wait states, illegal
// verdicts, start pulses mid-search and asynchronous reset during ASK.
module tb_sar_search;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] guess;
  logic         guess_valid;
  logic         resp_valid = 1'b0;
  logic         cmp_lt = 1'b0;
  logic         cmp_gt = 1'b0;
  logic         cmp_eq = 1'b0;
  logic         done;
  logic         found;
  logic         err;
  logic [W-1:0] result;
`ifdef SAR_STEP_CNT_EN
  logic [2:0]   steps;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  sar_search #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .guess       (guess),
    .guess_valid (guess_valid),
    .resp_valid  (resp_valid),
    .cmp_lt      (cmp_lt),
    .cmp_gt      (cmp_gt),
    .cmp_eq      (cmp_eq),
    .done        (done),
    .found       (found),
    .err         (err),
    .result      (result)
`ifdef SAR_STEP_CNT_EN
    ,
    .steps       (steps)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_steps(input string tag, input int exp);
`ifdef SAR_STEP_CNT_EN
    chk(tag, 32'(steps), 32'(exp));
`endif
  endtask

  // mode: 0 = answer from secret, 1 = always lt, 2 = always gt, 3 = lt and gt together.
  // expg holds the expected guess sequence, one nibble per guess, first guess lowest.
  task automatic run(input string name, input int secret, input int mode, input int waitc,
                     input logic [31:0] expg, input int expn, input logic exp_found,
                     input logic exp_err, input logic [3:0] exp_res, input int exp_cyc,
                     input bit pulse_start);
    int n = 0;
    int cyc = 0;
    int w = 0;
    bit fin = 0;
    logic [3:0] held = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({name, "_calc_gv"}, 32'(guess_valid), 32'd0);
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      resp_valid = 1'b0; cmp_lt = 1'b0; cmp_gt = 1'b0; cmp_eq = 1'b0; start = 1'b0;
      if (done) begin
        fin = 1;
        chk({name, "_n_guesses"}, 32'(n), 32'(expn));
        chk({name, "_found"}, 32'(found), 32'(exp_found));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_result"}, 32'(result), 32'(exp_res));
        chk({name, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk_steps({name, "_steps"}, expn);
      end else begin
        if (guess_valid) begin
          if (w == 0) begin
            chk({name, "_guess_idx_ok"}, 32'(n < expn), 32'd1);
            chk({name, "_guess"}, 32'(guess), 32'(expg[n*4 +: 4]));
            held = guess;
          end else begin
            chk({name, "_guess_held"}, 32'(guess), 32'(held));
          end
          if (w < waitc) begin
            w++;
          end else begin
            w = 0;
            n++;
            resp_valid = 1'b1;
            case (mode)
              0: begin
                cmp_lt = (int'(guess) < secret);
                cmp_gt = (int'(guess) > secret);
                cmp_eq = (int'(guess) == secret);
              end
              1: cmp_lt = 1'b1;
              2: cmp_gt = 1'b1;
              default: begin cmp_lt = 1'b1; cmp_gt = 1'b1; end
            endcase
          end
        end
        if (pulse_start) start = cyc[0];
      end
    end
    chk({name, "_no_timeout"}, 32'(fin), 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_found_held"}, 32'(found), 32'(exp_found));
    chk({name, "_result_held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    #1;
    chk("rst_guess", 32'(guess), 32'd0);
    chk("rst_gv", 32'(guess_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk_steps("rst_steps", 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run("s9",    9, 0, 0, 32'h0000_09B7, 3, 1'b1, 1'b0, 4'd9,  6,  1'b0);
    run("s15",  15, 0, 0, 32'h000F_EDB7, 5, 1'b1, 1'b0, 4'd15, 10, 1'b0);
    run("s0",    0, 0, 0, 32'h0000_0137, 4, 1'b1, 1'b0, 4'd0,  8,  1'b0);
    run("all_lt", 0, 1, 0, 32'h000F_EDB7, 5, 1'b0, 1'b0, 4'd0, 11, 1'b0);
    run("all_gt", 0, 2, 0, 32'h0000_0137, 4, 1'b0, 1'b0, 4'd0, 9,  1'b0);
    run("illegal", 0, 3, 0, 32'h0000_0007, 1, 1'b0, 1'b1, 4'd0, 2,  1'b0);
    run("wait3", 9, 0, 3, 32'h0000_09B7, 3, 1'b1, 1'b0, 4'd9,  15, 1'b1);

    // Reset asserted while a guess is outstanding.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_in_ask", 32'(guess_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_guess", 32'(guess), 32'd0);
    chk("arst_gv", 32'(guess_valid), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_found", 32'(found), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk_steps("arst_steps", 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run("s5_after_rst", 5, 0, 0, 32'h0000_0537, 3, 1'b1, 1'b0, 4'd5, 6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
